latch_bank_ctrl: RTL and testbench

Sequencer for a bank of `N_ENTRIES` gated D latches sharing one data bus. It accepts write requests over a valid/ready handshake and drives the shared data bus and a one-hot gate vector with guaranteed setup and hold margins around each gate pulse. It also accepts bank-clear requests and drives the bank's active-low clear. It sits between the register-file front end and the latch array, which is the only logic allowed to toggle latch gates.

---
 rtl/latch_ctrl_pkg.sv | 26 ++
 rtl/pulse_timer.sv | 47 ++++
 rtl/latch_bank_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_latch_bank_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latch_ctrl_pkg
// Description : Shared types and default constants for the latch bank
//               controller and its helpers.
//               - state_t : sequencer states (IDLE/SETUP/GATE/HOLD/CLEAR)
//               - c_DEF_* : default parameter values for latch_bank_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GATE  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam int unsigned c_DEF_N_ENTRIES = 8;
    localparam int unsigned c_DEF_DATA_W    = 8;
    localparam int unsigned c_DEF_GATE_CYC  = 2;
    localparam int unsigned c_DEF_CLR_CYC   = 1;

endpackage : latch_ctrl_pkg
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_timer
// Description : Loadable down-counter with a terminal (zero) flag. Shared by
//               the gate and clear phases of the latch bank sequencer.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               load_i         - load load_val_i into the counter
//               load_val_i     - value to load
//               dec_i          - decrement (saturates at zero)
//               zero_o         - counter equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : pulse_timer
`default_nettype wire

// File: rtl/latch_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_ctrl
// Description : Sequencer for a bank of gated D latches sharing one data bus.
//               Writes are taken over valid/ready and driven as
//               SETUP (data only) -> GATE (one-hot gate) -> HOLD (data only),
//               giving one cycle of data setup and hold around every gate
//               pulse. Bank clears drive the active-low clear for CLR_CYC
//               cycles. Clear requests win over writes while idle.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               req_valid/req_ready    - write handshake
//               req_addr, req_data     - write target and word
//               clr_req                - level request to clear the bank
//               clr_done, wr_done      - completion pulses
//               addr_err               - accepted address out of range
//               lat_d, lat_g           - latch data bus, one-hot gates
//               lat_clr_n              - active-low bank clear
//               busy                   - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned N_ENTRIES = c_DEF_N_ENTRIES,
    parameter int unsigned DATA_W    = c_DEF_DATA_W,
    parameter int unsigned GATE_CYC  = c_DEF_GATE_CYC,
    parameter int unsigned CLR_CYC   = c_DEF_CLR_CYC,
    parameter int unsigned ADDR_W    = $clog2(N_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    input  logic                 clr_req,
    output logic                 clr_done,
    output logic                 wr_done,
    output logic                 addr_err,
    output logic [DATA_W-1:0]    lat_d,
    output logic [N_ENTRIES-1:0] lat_g,
    output logic                 lat_clr_n,
    output logic                 busy
);

    localparam int unsigned c_max_cyc = (GATE_CYC > CLR_CYC) ? GATE_CYC : CLR_CYC;
    localparam int unsigned c_tmr_w   = $clog2(c_max_cyc) + 1;
    localparam logic [ADDR_W:0]        c_n_ent = (ADDR_W+1)'(N_ENTRIES);
    localparam logic [N_ENTRIES-1:0]   c_one   = {{(N_ENTRIES-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     lat_d_q, lat_d_d;
    logic [N_ENTRIES-1:0]  lat_g_q, lat_g_d;
    logic                  lat_clr_n_q, lat_clr_n_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  wr_done_q, wr_done_d;
    logic                  clr_done_q, clr_done_d;
    logic                  addr_err_q, addr_err_d;

    logic                  tmr_load;
    logic [c_tmr_w-1:0]    tmr_load_val;
    logic                  tmr_dec;
    logic                  tmr_zero;

    logic                  addr_oob;

    assign addr_oob = ({1'b0, req_addr} >= c_n_ent);

    pulse_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lat_d_d      = lat_d_q;
        wr_done_d    = 1'b0;
        clr_done_d   = 1'b0;
        addr_err_d   = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready_q is low only in the cycle right after reset release;
                // nothing is accepted there so the clear line can rise first.
                if (ready_q) begin
                    if (clr_req) begin
                        state_d      = ST_CLEAR;
                        tmr_load     = 1'b1;
                        tmr_load_val = c_tmr_w'(CLR_CYC - 1);
                    end else if (req_valid) begin
                        if (addr_oob) begin
                            addr_err_d = 1'b1;
                        end else begin
                            state_d = ST_SETUP;
                            addr_d  = req_addr;
                            // Bus changes only on the SETUP entry edge.
                            lat_d_d = req_data;
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_d      = ST_GATE;
                tmr_load     = 1'b1;
                tmr_load_val = c_tmr_w'(GATE_CYC - 1);
            end
            ST_GATE: begin
                if (tmr_zero) begin
                    state_d = ST_HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d   = ST_IDLE;
                wr_done_d = 1'b1;
            end
            ST_CLEAR: begin
                if (tmr_zero) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        lat_g_d     = (state_d == ST_GATE) ? (c_one << addr_d) : '0;
        lat_clr_n_d = (state_d != ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
        ready_d     = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            lat_d_q     <= '0;
            lat_g_q     <= '0;
            lat_clr_n_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            wr_done_q   <= 1'b0;
            clr_done_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lat_d_q     <= lat_d_d;
            lat_g_q     <= lat_g_d;
            lat_clr_n_q <= lat_clr_n_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            wr_done_q   <= wr_done_d;
            clr_done_q  <= clr_done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Clear has priority over a write in the same idle cycle.
    assign req_ready = ready_q & ~clr_req;
    assign clr_done  = clr_done_q;
    assign wr_done   = wr_done_q;
    assign addr_err  = addr_err_q;
    assign lat_d     = lat_d_q;
    assign lat_g     = lat_g_q;
    assign lat_clr_n = lat_clr_n_q;
    assign busy      = busy_q;

endmodule : latch_bank_ctrl
`default_nettype wire

// File: tb/tb_latch_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_bank_ctrl
// Description : Self-checking bench for latch_bank_ctrl. A transaction-level
//               model schedules expected outputs per cycle from each accepted
//               write/clear; a compare process checks every cycle. Directed
//               sequences pin specific literal values, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_bank_ctrl;

    localparam int unsigned N  = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned G  = 2;
    localparam int unsigned C  = 2;
    localparam int unsigned AW = $clog2(N);
    localparam int          SZ = 4096;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          clr_req   = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_data  = '0;
    logic          req_ready, clr_done, wr_done, addr_err, lat_clr_n, busy;
    logic [DW-1:0] lat_d;
    logic [N-1:0]  lat_g;

    always #5 clk = ~clk;

    latch_bank_ctrl #(
        .N_ENTRIES (N),
        .DATA_W    (DW),
        .GATE_CYC  (G),
        .CLR_CYC   (C),
        .ADDR_W    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .wr_done   (wr_done),
        .addr_err  (addr_err),
        .lat_d     (lat_d),
        .lat_g     (lat_g),
        .lat_clr_n (lat_clr_n),
        .busy      (busy)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int free_at = 0;
    bit run_chk = 1'b1;
    bit acc_wr  = 1'b0;
    bit acc_clr = 1'b0;

    // Expected per-cycle outputs, indexed by cycle number.
    bit [N-1:0]    e_g   [SZ];
    bit            e_clr [SZ];
    bit            e_busy[SZ];
    bit            e_wd  [SZ];
    bit            e_cd  [SZ];
    bit            e_err [SZ];
    logic [DW-1:0] e_ld = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit [N-1:0] onehot(input int a);
        bit [N-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: decide at each edge what the controller accepts and
    // schedule the resulting output waveform over the following cycles.
    always @(posedge clk) begin
        acc_wr  = 1'b0;
        acc_clr = 1'b0;
        if (rst) begin
            for (int k = cyc + 1; k <= cyc + 16; k++) begin
                e_g[k] = '0; e_clr[k] = 1'b0; e_busy[k] = 1'b0;
                e_wd[k] = 1'b0; e_cd[k] = 1'b0; e_err[k] = 1'b0;
            end
            e_clr[cyc+1] = 1'b1;
            e_ld         = '0;
            free_at      = cyc + 2;
        end else if (cyc >= free_at) begin
            if (clr_req) begin
                acc_clr = 1'b1;
                for (int k = 1; k <= int'(C); k++) begin
                    e_clr[cyc+k]  = 1'b1;
                    e_busy[cyc+k] = 1'b1;
                end
                e_cd[cyc+int'(C)+1] = 1'b1;
                free_at = cyc + int'(C) + 1;
            end else if (req_valid) begin
                acc_wr = 1'b1;
                if (int'(req_addr) >= int'(N)) begin
                    e_err[cyc+1] = 1'b1;
                end else begin
                    e_ld = req_data;
                    for (int k = 1; k <= int'(G) + 2; k++) e_busy[cyc+k] = 1'b1;
                    for (int k = 2; k <= int'(G) + 1; k++) e_g[cyc+k] = onehot(int'(req_addr));
                    e_wd[cyc+int'(G)+3] = 1'b1;
                    free_at = cyc + int'(G) + 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk && cyc >= 1) begin
            chk("lat_g",     32'(lat_g),     32'(e_g[cyc]));
            chk("lat_clr_n", 32'(lat_clr_n), 32'(!e_clr[cyc]));
            chk("busy",      32'(busy),      32'(e_busy[cyc]));
            chk("wr_done",   32'(wr_done),   32'(e_wd[cyc]));
            chk("clr_done",  32'(clr_done),  32'(e_cd[cyc]));
            chk("addr_err",  32'(addr_err),  32'(e_err[cyc]));
            chk("lat_d",     32'(lat_d),     32'(e_ld));
            chk("req_ready", 32'(req_ready), 32'((cyc >= free_at) && !clr_req));
            chk("gate_vs_clr", 32'((lat_g != '0) && !lat_clr_n), 32'(0));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (cyc < free_at && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(cyc < free_at), 32'(0));
    endtask

    initial begin
        int hs1, hs2;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_clr_n", 32'(lat_clr_n), 32'(0));
        chk("rst_g",     32'(lat_g),     32'(0));
        chk("rst_d",     32'(lat_d),     32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_busy",  32'(busy),      32'(0));
        rst = 1'b0;
        tick();
        chk("rel_clr_n", 32'(lat_clr_n), 32'(1));
        chk("rel_ready", 32'(req_ready), 32'(1));

        // Single write: addr 3, data A5
        req_valid = 1'b1; req_addr = 3'd3; req_data = 8'hA5;
        #1;
        chk("w_ready", 32'(req_ready), 32'(1));
        tick(); req_valid = 1'b0;
        chk("w_setup_g", 32'(lat_g), 32'(0));
        chk("w_setup_d", 32'(lat_d), 32'(8'hA5));
        tick();
        chk("w_gate1_g", 32'(lat_g), 32'(6'h08));
        tick();
        chk("w_gate2_g", 32'(lat_g), 32'(6'h08));
        tick();
        chk("w_hold_g", 32'(lat_g), 32'(0));
        chk("w_hold_d", 32'(lat_d), 32'(8'hA5));
        tick();
        chk("w_done",  32'(wr_done),   32'(1));
        chk("w_ready2", 32'(req_ready), 32'(1));

        // Back-to-back writes with valid held high
        req_valid = 1'b1; req_addr = 3'd0; req_data = 8'h3C;
        hs1 = -1; hs2 = -1;
        for (int i = 0; i < 20 && hs2 < 0; i++) begin
            #1;
            if (req_ready) begin
                if (hs1 < 0) hs1 = cyc;
                else         hs2 = cyc;
            end
            tick();
            if (hs1 >= 0 && hs2 < 0) begin
                req_addr = 3'd5; req_data = 8'hC3;
            end
        end
        req_valid = 1'b0;
        chk("b2b_period", 32'(hs2 - hs1), 32'(5));
        wait_idle();

        // Clear and write together while idle
        clr_req = 1'b1; req_valid = 1'b1; req_addr = 3'd2; req_data = 8'h5A;
        #1;
        chk("cw_ready", 32'(req_ready), 32'(0));
        tick(); clr_req = 1'b0;
        chk("cw_clr1", 32'(lat_clr_n), 32'(0));
        tick();
        chk("cw_clr2", 32'(lat_clr_n), 32'(0));
        tick();
        chk("cw_done",   32'(clr_done),  32'(1));
        chk("cw_clr_up", 32'(lat_clr_n), 32'(1));
        chk("cw_ready2", 32'(req_ready), 32'(1));
        tick(); req_valid = 1'b0;
        chk("cw_wr_busy", 32'(busy),  32'(1));
        chk("cw_wr_d",    32'(lat_d), 32'(8'h5A));
        wait_idle();

        // Clear raised during GATE
        req_valid = 1'b1; req_addr = 3'd1; req_data = 8'h11;
        tick(); req_valid = 1'b0;
        tick(); clr_req = 1'b1;
        tick(); tick();
        chk("cg_hold_clr_n", 32'(lat_clr_n), 32'(1));
        tick();
        chk("cg_wr_done",  32'(wr_done),   32'(1));
        chk("cg_idle_clr", 32'(lat_clr_n), 32'(1));
        tick(); clr_req = 1'b0;
        chk("cg_clr_start", 32'(lat_clr_n), 32'(0));
        tick(); tick();
        chk("cg_clr_done", 32'(clr_done), 32'(1));

        // Out-of-range address
        req_valid = 1'b1; req_addr = 3'd7; req_data = 8'hFF;
        tick(); req_valid = 1'b0;
        chk("ae_pulse", 32'(addr_err), 32'(1));
        chk("ae_g",     32'(lat_g),    32'(0));
        chk("ae_d",     32'(lat_d),    32'(8'h11));
        chk("ae_busy",  32'(busy),     32'(0));
        tick();
        chk("ae_once", 32'(addr_err), 32'(0));

        // Reset during GATE
        req_valid = 1'b1; req_addr = 3'd4; req_data = 8'h77;
        tick(); req_valid = 1'b0;
        tick();
        chk("rg_gate", 32'(lat_g), 32'(6'h10));
        rst = 1'b1;
        tick();
        chk("rg_g",     32'(lat_g),     32'(0));
        chk("rg_clr_n", 32'(lat_clr_n), 32'(0));
        chk("rg_wd",    32'(wr_done),   32'(0));
        rst = 1'b0;
        tick();
        chk("rg_rel_clr_n", 32'(lat_clr_n), 32'(1));
        chk("rg_rel_ready", 32'(req_ready), 32'(1));
        repeat (6) tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 199) == 0);
            if (acc_clr) clr_req = 1'b0;
            if (!clr_req && $urandom_range(0, 24) == 0)     clr_req = 1'b1;
            else if (clr_req && $urandom_range(0, 15) == 0) clr_req = 1'b0;
            if (acc_wr) req_valid = 1'b0;
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_addr  = AW'($urandom_range(0, 7));
                req_data  = DW'($urandom);
            end
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; clr_req = 1'b0;
        repeat (10) tick();

        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_latch_bank_ctrl
`default_nettype wire
